// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler, GTCCR register and T-pin edge front end.
// Optional macro ATMEGA_PRESC_T_DSYNC_EN adds a flop to the T-pin synchroniser for an asynchronous t.
module atmega_tim_prescaler #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR        = 'h43
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  input  logic                         t,
  output logic                         clk8,
  output logic                         clk64,
  output logic                         clk256,
  output logic                         clk1024,
  output logic                         t_rise,
  output logic                         t_fall,
  output logic                         psr_async
);

  logic [9:0] cnt;
  logic       tsm;
  logic       psrasy;
  logic       psrsync;
  logic       s2;
  logic       s3;
  logic       gtccr_sel;
  logic       gtccr_wr;
  logic       unused_bus_bits;

  assign gtccr_sel       = (addr == GTCCR_ADDR);
  assign gtccr_wr        = wr & gtccr_sel;
  assign unused_bus_bits = ^bus_in[6:2];

  // A PSRSYNC write clears the counter on the write edge itself; the stored bit keeps it clear after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      tsm     <= 1'b0;
      psrasy  <= 1'b0;
      psrsync <= 1'b0;
    end else begin
      if ((gtccr_wr & bus_in[0]) | psrsync)
        cnt <= '0;
      else if (!halt)
        cnt <= cnt + 10'd1;

      if (gtccr_wr) begin
        tsm     <= bus_in[7];
        psrasy  <= bus_in[1];
        psrsync <= bus_in[0];
      end else if (!tsm) begin
        psrasy  <= 1'b0;
        psrsync <= 1'b0;
      end
    end
  end

  assign clk8      = cnt[2];
  assign clk64     = cnt[5];
  assign clk256    = cnt[7];
  assign clk1024   = cnt[9];
  assign psr_async = psrasy;

  assign bus_out = (rst && rd && gtccr_sel) ? {tsm, 5'b0, psrasy, psrsync} : 8'h00;

`ifdef ATMEGA_PRESC_T_DSYNC_EN
  logic s1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= t;
      s2 <= s1;
      s3 <= s2;
    end
  end
`else
  // t is assumed synchronous to clk here, so one flop less latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s2 <= t;
      s3 <= s2;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      t_rise <= 1'b0;
      t_fall <= 1'b0;
    end else begin
      t_rise <= s2 & ~s3;
      t_fall <= ~s2 & s3;
    end
  end

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Directed bench for atmega_tim_prescaler: vector table plus multi-cycle sequences.
module tb_atmega_tim_prescaler;

`ifdef ATMEGA_PRESC_T_DSYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, halt, wr, rd, t;
  logic [7:0] addr, bus_in, bus_out;
  logic       clk8, clk64, clk256, clk1024, t_rise, t_fall, psr_async;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  atmega_tim_prescaler #(.BUS_ADDR_DATA_LEN(8), .GTCCR_ADDR(8'h43)) dut (
    .clk(clk), .rst(rst), .halt(halt), .addr(addr), .wr(wr), .rd(rd),
    .bus_in(bus_in), .bus_out(bus_out), .t(t),
    .clk8(clk8), .clk64(clk64), .clk256(clk256), .clk1024(clk1024),
    .t_rise(t_rise), .t_fall(t_fall), .psr_async(psr_async)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, halt, wr, rd;
    logic [7:0] addr, din;
    logic [3:0] eclk;
    logic [7:0] ebus;
    logic       epsr;
  } vec_t;

  vec_t tbl[21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] clkv(input int c);
    logic [9:0] cc;
    cc = c[9:0];
    return {cc[9], cc[7], cc[5], cc[2]};
  endfunction

  task automatic chk_cnt(input string nm);
    chk(nm, {12'd0, clk1024, clk256, clk64, clk8}, {12'd0, clkv(ecnt)});
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      step();
      if (!halt) ecnt = (ecnt + 1) % 1024;
      chk_cnt(nm);
    end
  endtask

  initial begin
    rst = 1'b0; halt = 1'b0; wr = 1'b0; rd = 1'b0; t = 1'b0;
    addr = 8'h43; bus_in = 8'h00;

    //           rst   halt  wr    rd    addr   din    eclk  ebus   epsr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 8'hFF, 4'h0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 8'h81, 4'h0, 8'h81, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h81, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h81, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 8'h82, 4'h0, 8'h82, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h1, 8'h82, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 8'h02, 4'h1, 8'h02, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h1, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 8'h00, 4'h1, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 8'hFF, 4'h0, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 8'h01, 4'h0, 8'h01, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h43, 8'h81, 4'h0, 8'h81, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 8'h00, 4'h0, 8'h00, 1'b0};

    #2;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; halt = tbl[i].halt; wr = tbl[i].wr; rd = tbl[i].rd;
      addr = tbl[i].addr; bus_in = tbl[i].din;
      step();
      chk($sformatf("vec%0d_clk", i), {12'd0, clk1024, clk256, clk64, clk8}, {12'd0, tbl[i].eclk});
      chk($sformatf("vec%0d_bus", i), {8'd0, bus_out}, {8'd0, tbl[i].ebus});
      chk($sformatf("vec%0d_psr", i), {15'd0, psr_async}, {15'd0, tbl[i].epsr});
      chk($sformatf("vec%0d_tedge", i), {14'd0, t_rise, t_fall}, 16'd0);
    end

    // Free run from reset release through a full wrap.
    halt = 1'b0; wr = 1'b0; rd = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1; ecnt = 0;
    run(1030, "freerun");

    // PSRSYNC write after 300 free-running cycles.
    rst = 1'b0; step(); rst = 1'b1; ecnt = 0;
    run(300, "run300");
    wr = 1'b1; rd = 1'b1; bus_in = 8'h01;
    step(); ecnt = 0; chk_cnt("psrsync_w0"); chk("psrsync_rd0", {8'd0, bus_out}, 16'h0001);
    wr = 1'b0; bus_in = 8'h00;
    step(); ecnt = 0; chk_cnt("psrsync_w1"); chk("psrsync_rd1", {8'd0, bus_out}, 16'h0000);
    run(5, "psrsync_resume");

    // TSM hold for 50 cycles, then release.
    wr = 1'b1; bus_in = 8'h81;
    step(); ecnt = 0; chk_cnt("tsm_w");
    wr = 1'b0; bus_in = 8'h00;
    for (int i = 0; i < 50; i++) begin
      step();
      chk_cnt("tsm_hold");
      chk("tsm_rd", {8'd0, bus_out}, 16'h0081);
    end
    wr = 1'b1; bus_in = 8'h00;
    step(); ecnt = 0; chk_cnt("tsm_rel0");
    wr = 1'b0;
    run(3, "tsm_rel");

    // T-pin rising then falling edge.
    t = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); ecnt = (ecnt + 1) % 1024;
      chk($sformatf("t_rise_%0d", i), {15'd0, t_rise}, {15'd0, (i == LAT)});
      chk($sformatf("t_fall_r%0d", i), {15'd0, t_fall}, 16'd0);
    end
    t = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); ecnt = (ecnt + 1) % 1024;
      chk($sformatf("t_fall_%0d", i), {15'd0, t_fall}, {15'd0, (i == LAT)});
      chk($sformatf("t_rise_f%0d", i), {15'd0, t_rise}, 16'd0);
    end
    chk_cnt("after_t");

    // Halt freezes the counter but not the T-pin path; reset during halt.
    run(37, "pre_halt");
    halt = 1'b1; t = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_cnt("halt_frozen");
      chk($sformatf("halt_t_rise_%0d", i), {15'd0, t_rise}, {15'd0, (i == LAT)});
    end
    rst = 1'b0; rd = 1'b1;
    step();
    chk("halt_rst_clk", {12'd0, clk1024, clk256, clk64, clk8}, 16'd0);
    chk("halt_rst_bus", {8'd0, bus_out}, 16'd0);
    chk("halt_rst_tedge", {14'd0, t_rise, t_fall}, 16'd0);
    chk("halt_rst_psr", {15'd0, psr_async}, 16'd0);

    // t held high through reset release gives one rise pulse.
    step();
    halt = 1'b0; rst = 1'b1; rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rel_t_rise_%0d", i), {15'd0, t_rise}, {15'd0, (i == LAT)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
